snake_body_writer: RTL and testbench

SNAKE_BODY_WRITER -- requirements
Module: snake_body_writer

---
 rtl/snake_pkg.sv | 20 ++
 rtl/snake_next_head.sv | 34 +++
 rtl/snake_body_writer.sv | 118 +++++++++++
 tb/tb_snake_body_writer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared snake encodings, layout constants and FSM state type.
// Build option: SNAKE_WRAP_EN (consumed by snake_next_head) makes walls wrap.
package snake_pkg;
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;
  localparam logic [31:0] EMPTY_COORD = 32'hFFFF_FFFF;
  localparam int INIT_HEAD_X = 4;
  localparam int INIT_HEAD_Y = 5;
  localparam int INIT_LEN    = 3;
  typedef enum logic [2:0] {RUN, CALC, SCAN, COMMIT, DONE} state_t;
  // Initial body trails horizontally to the left of the head.
  function automatic logic [31:0] init_x(int j);
    return j < INIT_LEN ? 32'(INIT_HEAD_X - j) : EMPTY_COORD;
  endfunction
  function automatic logic [31:0] init_y(int j);
    return j < INIT_LEN ? 32'(INIT_HEAD_Y) : EMPTY_COORD;
  endfunction
endpackage

// File: rtl/snake_next_head.sv
// snake_next_head: combinational next-head tile, wall detection and optional wrap.
// Ports: head_x/head_y current head, dir step direction (0 up, 1 right, 2 down, 3 left),
//        next_x/next_y stepped head, wall high when the step leaves the grid.
// Build option: SNAKE_WRAP_EN wraps off-grid steps to the opposite edge and never reports wall.
module snake_next_head import snake_pkg::*; #(
  parameter int GRID_W = 10,
  parameter int GRID_H = 10
) (
  input  logic [31:0] head_x,
  input  logic [31:0] head_y,
  input  logic [1:0]  dir,
  output logic [31:0] next_x,
  output logic [31:0] next_y,
  output logic        wall
);
  localparam logic [31:0] XMAX = 32'(GRID_W - 1);
  localparam logic [31:0] YMAX = 32'(GRID_H - 1);
  logic lo_x, hi_x, lo_y, hi_y;
  always_comb begin
    lo_x = dir == DIR_LEFT  && head_x == 32'd0;
    hi_x = dir == DIR_RIGHT && head_x == XMAX;
    lo_y = dir == DIR_UP    && head_y == 32'd0;
    hi_y = dir == DIR_DOWN  && head_y == YMAX;
`ifdef SNAKE_WRAP_EN
    next_x = lo_x ? XMAX : hi_x ? 32'd0 : dir == DIR_RIGHT ? head_x + 32'd1 : dir == DIR_LEFT ? head_x - 32'd1 : head_x;
    next_y = lo_y ? YMAX : hi_y ? 32'd0 : dir == DIR_DOWN ? head_y + 32'd1 : dir == DIR_UP ? head_y - 32'd1 : head_y;
    wall = 1'b0;
`else
    next_x = dir == DIR_RIGHT ? head_x + 32'd1 : dir == DIR_LEFT ? head_x - 32'd1 : head_x;
    next_y = dir == DIR_DOWN ? head_y + 32'd1 : dir == DIR_UP ? head_y - 32'd1 : head_y;
    wall = lo_x | hi_x | lo_y | hi_y;
`endif
  end
endmodule

// File: rtl/snake_body_writer.sv
// snake_body_writer: snake body state machine stepping one tile per tick.
// Ports: clk, reset (async active-low), start restart strobe, tick step strobe,
//        dir requested direction, food_x/food_y food tile,
//        x_values/y_values packed slots (slot 0 = head, unused = all ones),
//        length occupied slots, ate food pulse, game_done level, busy step in flight.
// Build option: SNAKE_WRAP_EN (see snake_next_head) wraps instead of ending the game at walls.
module snake_body_writer import snake_pkg::*; #(
  parameter int MAX_LEN = 100,
  parameter int GRID_W  = 10,
  parameter int GRID_H  = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   tick,
  input  logic [1:0]             dir,
  input  logic [31:0]            food_x,
  input  logic [31:0]            food_y,
  output logic [32*MAX_LEN-1:0]  x_values,
  output logic [32*MAX_LEN-1:0]  y_values,
  output logic [7:0]             length,
  output logic                   ate,
  output logic                   game_done,
  output logic                   busy
);
  localparam int IW = $clog2(MAX_LEN);
  state_t state;
  logic [1:0] cur_dir;
  logic [31:0] xs [MAX_LEN];
  logic [31:0] ys [MAX_LEN];
  logic [31:0] nx, ny, calc_x, calc_y;
  logic wall, grow, hit;
  logic [IW-1:0] idx;
  logic [7:0] last;
  snake_next_head #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_next (
    .head_x(xs[0]),
    .head_y(ys[0]),
    .dir(cur_dir),
    .next_x(calc_x),
    .next_y(calc_y),
    .wall(wall)
  );
  assign hit = xs[idx] == nx && ys[idx] == ny;
  // When not growing the tail vacates its tile this step, so it is excluded from the scan.
  assign last = grow ? length - 8'd1 : length - 8'd2;
  for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
    assign x_values[32*g +: 32] = xs[g];
    assign y_values[32*g +: 32] = ys[g];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= RUN;
      cur_dir <= DIR_RIGHT;
      length <= 8'(INIT_LEN);
      for (int j = 0; j < MAX_LEN; j++) begin
        xs[j] <= init_x(j);
        ys[j] <= init_y(j);
      end
      nx <= '0;
      ny <= '0;
      grow <= 1'b0;
      idx <= '0;
      ate <= 1'b0;
      busy <= 1'b0;
      game_done <= 1'b0;
    end else begin
      ate <= 1'b0;
      if (start) begin
        state <= RUN;
        cur_dir <= DIR_RIGHT;
        length <= 8'(INIT_LEN);
        for (int j = 0; j < MAX_LEN; j++) begin
          xs[j] <= init_x(j);
          ys[j] <= init_y(j);
        end
        busy <= 1'b0;
        game_done <= 1'b0;
      end else
        case (state)
          RUN: if (tick) begin
            cur_dir <= (dir ^ 2'd2) == cur_dir ? cur_dir : dir;
            state <= CALC;
            busy <= 1'b1;
          end
          CALC: begin
            nx <= calc_x;
            ny <= calc_y;
            grow <= calc_x == food_x && calc_y == food_y;
            idx <= '0;
            state <= wall ? DONE : SCAN;
            busy <= !wall;
            game_done <= wall;
          end
          SCAN:
            if (hit) begin
              state <= DONE;
              busy <= 1'b0;
              game_done <= 1'b1;
            end else if (8'(idx) == last) state <= COMMIT;
            else idx <= idx + 1'b1;
          COMMIT: begin
            // Slot length receives the old tail on a non-growing step; blank it. When full,
            // the tail simply shifts off the end.
            for (int j = 1; j < MAX_LEN; j++) begin
              xs[j] <= !grow && 8'(j) == length ? EMPTY_COORD : xs[j-1];
              ys[j] <= !grow && 8'(j) == length ? EMPTY_COORD : ys[j-1];
            end
            xs[0] <= nx;
            ys[0] <= ny;
            if (grow && length < 8'(MAX_LEN)) length <= length + 8'd1;
            ate <= grow;
            state <= RUN;
            busy <= 1'b0;
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_snake_body_writer.sv
// tb_snake_body_writer: directed self-checking bench for snake_body_writer.
module tb_snake_body_writer;
  localparam int MAX_LEN = 100;
  localparam logic [31:0] E = 32'hFFFF_FFFF;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, tick = 1'b0;
  logic [1:0] dir = 2'd0;
  logic [31:0] food_x = 32'd50, food_y = 32'd50;
  logic [32*MAX_LEN-1:0] x_values, y_values;
  logic [7:0] length;
  logic ate, game_done, busy;
  int errors = 0, checks = 0, ate_cnt = 0, lat;
  snake_body_writer #(.MAX_LEN(MAX_LEN), .GRID_W(10), .GRID_H(10)) dut (
    .clk(clk), .reset(reset), .start(start), .tick(tick), .dir(dir),
    .food_x(food_x), .food_y(food_y), .x_values(x_values), .y_values(y_values),
    .length(length), .ate(ate), .game_done(game_done), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (ate) ate_cnt++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] sx(int j);
    return x_values[32*j +: 32];
  endfunction
  function automatic logic [31:0] sy(int j);
    return y_values[32*j +: 32];
  endfunction
  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask
  // Returns the number of rising edges after the tick-sampling edge until busy drops.
  task automatic step(input logic [1:0] d, output int n);
    @(negedge clk);
    tick = 1'b1;
    dir = d;
    @(negedge clk);
    tick = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask
  initial begin
    do_reset();
    check("rst_len", 32'(length), 32'd3);
    check("rst_s0x", sx(0), 32'd4);
    check("rst_s0y", sy(0), 32'd5);
    check("rst_s1x", sx(1), 32'd3);
    check("rst_s2x", sx(2), 32'd2);
    check("rst_s2y", sy(2), 32'd5);
    check("rst_s3x", sx(3), E);
    check("rst_s99y", sy(99), E);
    check("rst_flags", {29'd0, ate, game_done, busy}, 32'd0);
    step(2'd1, lat);
    check("move_lat", 32'(lat), 32'd4);
    check("move_s0x", sx(0), 32'd5);
    check("move_s0y", sy(0), 32'd5);
    check("move_s2x", sx(2), 32'd3);
    check("move_s3x", sx(3), E);
    check("move_len", 32'(length), 32'd3);
    check("move_ate", 32'(ate), 32'd0);
    do_reset();
    food_x = 32'd5;
    food_y = 32'd5;
    ate_cnt = 0;
    step(2'd1, lat);
    check("grow_lat", 32'(lat), 32'd5);
    check("grow_ate", 32'(ate), 32'd1);
    check("grow_len", 32'(length), 32'd4);
    check("grow_s3x", sx(3), 32'd2);
    check("grow_s3y", sy(3), 32'd5);
    check("grow_s4x", sx(4), E);
    food_x = 32'd50;
    repeat (4) @(negedge clk);
    check("grow_ate_once", 32'(ate_cnt), 32'd1);
    do_reset();
    step(2'd3, lat);
    check("rev_s0x", sx(0), 32'd5);
    check("rev_s0y", sy(0), 32'd5);
    do_reset();
    for (int i = 0; i < 5; i++) step(2'd1, lat);
    check("edge_s0x", sx(0), 32'd9);
    step(2'd1, lat);
`ifdef SNAKE_WRAP_EN
    check("wrap_s0x", sx(0), 32'd0);
    check("wrap_s0y", sy(0), 32'd5);
    check("wrap_done", 32'(game_done), 32'd0);
`else
    check("wall_done", 32'(game_done), 32'd1);
    check("wall_s0x", sx(0), 32'd9);
    check("wall_s1x", sx(1), 32'd8);
    check("wall_len", 32'(length), 32'd3);
    check("wall_busy", 32'(busy), 32'd0);
    step(2'd2, lat);
    check("done_tick_s0y", sy(0), 32'd5);
    check("done_tick_done", 32'(game_done), 32'd1);
`endif
    do_reset();
    food_x = 32'd5;
    food_y = 32'd5;
    step(2'd1, lat);
    food_x = 32'd6;
    step(2'd1, lat);
    check("coil_grow_lat", 32'(lat), 32'd6);
    food_x = 32'd50;
    check("coil_len", 32'(length), 32'd5);
    step(2'd2, lat);
    step(2'd3, lat);
    check("coil_s0x", sx(0), 32'd5);
    check("coil_s0y", sy(0), 32'd6);
    step(2'd0, lat);
    check("coil_done", 32'(game_done), 32'd1);
    check("coil_hold_s0y", sy(0), 32'd6);
    check("coil_hold_len", 32'(length), 32'd5);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_done", 32'(game_done), 32'd0);
    check("start_len", 32'(length), 32'd3);
    check("start_s0x", sx(0), 32'd4);
    check("start_s3x", sx(3), E);
    check("start_s4y", sy(4), E);
    @(negedge clk);
    tick = 1'b1;
    dir = 2'd1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    lat = 0;
    while (busy && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    repeat (8) @(negedge clk);
    check("scan_tick_s0x", sx(0), 32'd5);
    check("scan_tick_busy", 32'(busy), 32'd0);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_s0x", sx(0), 32'd4);
    check("abort_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_idle_s0x", sx(0), 32'd4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
